// File: rtl/sr_latch_driver_if.sv
// Button-side and latch-side signals of sr_latch_driver grouped as one bundle.
// The master side drives the raw buttons; the slave side (the driver) returns
// the latch drives, busy, the completed-command count and a state debug view.
// With SR_DRIVER_TOGGLE_EN defined, a btn_toggle button is added.
//
// Handshake: there is no valid/ready pair. A button press is a level on a raw
// input. The driver accepts a new command only while busy=0. Any request seen
// while busy=1 is dropped, so the master never needs to wait on a ready.
interface sr_latch_driver_if #(
  parameter int CNT_W = 8
);
  logic             btn_set;
  logic             btn_reset;
`ifdef SR_DRIVER_TOGGLE_EN
  logic             btn_toggle;
`endif
  logic             S;
  logic             R;
  logic             E;
  logic             busy;
  logic [CNT_W-1:0] cmd_count;
  logic [1:0]       state_dbg;

`ifdef SR_DRIVER_TOGGLE_EN
  modport master (
    output btn_set, btn_reset, btn_toggle,
    input  S, R, E, busy, cmd_count, state_dbg
  );
  modport slave (
    input  btn_set, btn_reset, btn_toggle,
    output S, R, E, busy, cmd_count, state_dbg
  );
`else
  modport master (
    output btn_set, btn_reset,
    input  S, R, E, busy, cmd_count, state_dbg
  );
  modport slave (
    input  btn_set, btn_reset,
    output S, R, E, busy, cmd_count, state_dbg
  );
`endif
endinterface

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: turns raw, bouncing push buttons into clean SET/RESET
// commands for a downstream gated SR latch. Each button is synchronized and
// then debounced. A debounced rising edge starts one SETUP/ENABLE/HOLD
// sequence: S or R is set up one cycle before E rises, E is held for
// PULSE_CYCLES cycles, and S or R is kept for one cycle after E falls.
// Optional macro SR_DRIVER_TOGGLE_EN adds a toggle button. The toggle button
// picks RESET or SET from the last completed command.
module sr_latch_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = 8
) (
  input logic             clk,
  input logic             rst,
  sr_latch_driver_if.slave bus
);

  // Button index: 0 = set, 1 = reset, 2 = toggle (when enabled)
`ifdef SR_DRIVER_TOGGLE_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  logic [NB-1:0]    btn_raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    level;
  logic [NB-1:0]    rise;
  logic [DW-1:0]    db_cnt [NB];

  state_t           state;
  logic             cmd_reset;
  logic [PW-1:0]    pulse_cnt;
  logic             s_q;
  logic             r_q;
  logic             e_q;
  logic             busy_q;
  logic [CNT_W-1:0] cmd_count_q;
  logic             req_valid;
  logic             req_reset;
`ifdef SR_DRIVER_TOGGLE_EN
  logic             q_track;
`endif

`ifdef SR_DRIVER_TOGGLE_EN
  assign btn_raw = {bus.btn_toggle, bus.btn_reset, bus.btn_set};
`else
  assign btn_raw = {bus.btn_reset, bus.btn_set};
`endif

  // Synchronize each button, debounce it, and emit a one-cycle strobe on a debounced rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      rise  <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < NB; i++) begin
        rise[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          // The Nth consecutive differing sample commits the new level
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
            rise[i]   <= sync2[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Arbitrate simultaneous strobes: reset beats set, and set beats toggle
  always_comb begin
    req_valid = rise[0] | rise[1];
    req_reset = rise[1];
`ifdef SR_DRIVER_TOGGLE_EN
    req_valid = req_valid | rise[2];
    req_reset = rise[1] | (~rise[0] & rise[2] & q_track);
`endif
  end

  // Command FSM; the latch drives are registered and change on the same edge as the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_reset   <= 1'b0;
      pulse_cnt   <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      cmd_count_q <= '0;
`ifdef SR_DRIVER_TOGGLE_EN
      q_track     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          s_q <= 1'b0;
          r_q <= 1'b0;
          e_q <= 1'b0;
          if (req_valid) begin
            cmd_reset <= req_reset;
            s_q       <= ~req_reset;
            r_q       <= req_reset;
            busy_q    <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          e_q       <= 1'b1;
          pulse_cnt <= '0;
          state     <= ENABLE;
        end
        ENABLE: begin
          if (pulse_cnt == PW'(PULSE_CYCLES - 1)) begin
            e_q   <= 1'b0;
            state <= HOLD;
          end else begin
            pulse_cnt <= pulse_cnt + PW'(1);
          end
        end
        HOLD: begin
          s_q         <= 1'b0;
          r_q         <= 1'b0;
          busy_q      <= 1'b0;
          cmd_count_q <= cmd_count_q + CNT_W'(1);
`ifdef SR_DRIVER_TOGGLE_EN
          q_track     <= ~cmd_reset;
`endif
          state       <= IDLE;
        end
        default: begin
          s_q    <= 1'b0;
          r_q    <= 1'b0;
          e_q    <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.S         = s_q;
  assign bus.R         = r_q;
  assign bus.E         = e_q;
  assign bus.busy      = busy_q;
  assign bus.cmd_count = cmd_count_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver at its default parameters. Each completed command
// is summarised as {S cycles, R cycles, E cycles, protocol violations} and
// compared against the record queued when its button press was driven.
module tb_sr_latch_driver;

  localparam int CNT_W = 8;
  localparam int PULSE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sr_latch_driver_if #(.CNT_W(CNT_W)) bus ();

  sr_latch_driver #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (PULSE),
    .CNT_W          (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int          exp_count = 0;

  function automatic logic [15:0] rec(input bit is_reset);
    if (is_reset) return {4'd0, 4'(PULSE + 2), 4'(PULSE), 4'd0};
    else          return {4'(PULSE + 2), 4'd0, 4'(PULSE), 4'd0};
  endfunction

  task automatic expect_cmd(input bit is_reset);
    exp_q.push_back(rec(is_reset));
    exp_count++;
  endtask

  // ---------------- monitor ----------------
  logic [3:0] cur_s, cur_r, cur_e, cur_v;
  logic       prev_s, prev_r, prev_e, prev_busy;
  int         stray = 0;

  always @(negedge clk) begin
    if (rst) begin
      cur_s = 0; cur_r = 0; cur_e = 0; cur_v = 0;
      prev_s = 0; prev_r = 0; prev_e = 0; prev_busy = 0;
    end else begin
      if (bus.S && bus.R) cur_v++;
      if (bus.E && !(bus.S ^ bus.R)) cur_v++;
      if ((bus.E != prev_e) && ({bus.S, bus.R} != {prev_s, prev_r})) cur_v++;
      if (!bus.busy && (bus.S || bus.R || bus.E)) stray++;
      if (bus.busy) begin
        cur_s += 4'(bus.S);
        cur_r += 4'(bus.R);
        cur_e += 4'(bus.E);
      end
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) check("unexpected_cmd_queue", 32'(exp_q.size()), 32'd1);
        else check("cmd_rec", {16'd0, cur_s, cur_r, cur_e, cur_v}, {16'd0, exp_q.pop_front()});
        cur_s = 0; cur_r = 0; cur_e = 0; cur_v = 0;
      end
      prev_s = bus.S; prev_r = bus.R; prev_e = bus.E; prev_busy = bus.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_quiet();
    int i;
    idle(12);
    for (i = 0; i < 40; i++) begin
      if (!bus.busy) break;
      @(negedge clk);
    end
    if (i == 40) check("idle_timeout", 32'(bus.busy), 32'd0);
    idle(2);
  endtask

  task automatic press(input bit set_b, input bit reset_b, input int cycles);
    bus.btn_set   = set_b;
    bus.btn_reset = reset_b;
    idle(cycles);
    bus.btn_set   = 1'b0;
    bus.btn_reset = 1'b0;
  endtask

  task automatic check_count(input string tag);
    check(tag, 32'(bus.cmd_count), 32'(exp_count % (1 << CNT_W)));
  endtask

  // ---------------- stimulus ----------------
  int lat_e, lat_idle;

  initial begin
    bus.btn_set   = 1'b0;
    bus.btn_reset = 1'b0;
`ifdef SR_DRIVER_TOGGLE_EN
    bus.btn_toggle = 1'b0;
`endif
    rst = 1'b1;
    idle(3);
    check("rst_S", 32'(bus.S), 0);
    check("rst_R", 32'(bus.R), 0);
    check("rst_E", 32'(bus.E), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_count", 32'(bus.cmd_count), 0);
    rst = 1'b0;
    idle(3);

    // Set held 20 cycles: one SET command with fixed latency
    expect_cmd(1'b0);
    bus.btn_set = 1'b1;
    lat_e = 0;
    lat_idle = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.E && lat_e == 0) lat_e = i;
      if (lat_e != 0 && i > lat_e && !bus.busy && lat_idle == 0) lat_idle = i;
      if (i == 20) bus.btn_set = 1'b0;
    end
    check("lat_e_rise", 32'(lat_e), 32'd8);
    check("lat_busy_low", 32'(lat_idle), 32'd11);
    wait_quiet();
    check_count("count_after_set");

    // Reset button bouncing 3 high / 3 low: never debounced
    for (int k = 0; k < 5; k++) begin
      bus.btn_reset = 1'b1;
      idle(3);
      bus.btn_reset = 1'b0;
      idle(3);
    end
    wait_quiet();
    check("glitch_busy", 32'(bus.busy), 0);
    check_count("count_after_glitch");

    // Both buttons rise together: reset wins
    expect_cmd(1'b1);
    press(1'b1, 1'b1, 10);
    wait_quiet();
    check_count("count_after_simul");

    // Reset pressed while a set command is running: dropped
    expect_cmd(1'b0);
    bus.btn_set = 1'b1;
    idle(3);
    bus.btn_reset = 1'b1;
    idle(12);
    bus.btn_set   = 1'b0;
    bus.btn_reset = 1'b0;
    wait_quiet();
    check_count("count_busy_drop");
    expect_cmd(1'b1);
    press(1'b0, 1'b1, 10);
    wait_quiet();
    check_count("count_repress");

    // Reset during ENABLE aborts immediately, without a clock edge
    bus.btn_set = 1'b1;
    lat_e = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.E) begin lat_e = 1; break; end
    end
    check("abort_reached_enable", 32'(lat_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_S", 32'(bus.S), 0);
    check("abort_R", 32'(bus.R), 0);
    check("abort_E", 32'(bus.E), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_count", 32'(bus.cmd_count), 0);
    exp_count = 0;
    idle(2);
    bus.btn_set = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(12);
    check_count("count_after_abort");

    // Button held across reset release: exactly one command
    rst = 1'b1;
    bus.btn_set = 1'b1;
    idle(3);
    rst = 1'b0;
    expect_cmd(1'b0);
    idle(15);
    bus.btn_set = 1'b0;
    wait_quiet();
    check_count("count_held_reset");

    // Random presses
    for (int k = 0; k < 6; k++) begin
      bit is_rst;
      is_rst = 1'($urandom_range(0, 1));
      expect_cmd(is_rst);
      press(!is_rst, is_rst, $urandom_range(6, 12));
      wait_quiet();
      check_count("count_random");
    end

    idle(5);
    check("pending_cmds", 32'(exp_q.size()), 0);
    check("idle_stray_drive", 32'(stray), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4; consecutive stable synchronized samples a button must hold before its debounced level changes (min 1).
REQ-002 Parameter PULSE_CYCLES, default 2; cycles E is held high per command (min 1).
REQ-003 Parameter CNT_W, default 8; width of cmd_count.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 btn_set  input  1  raw, asynchronous set request button.
REQ-007 btn_reset  input  1  raw, asynchronous reset request button.
REQ-008 S  output  1  set drive to downstream gated SR latch.
REQ-009 R  output  1  reset drive to downstream gated SR latch.
REQ-010 E  output  1  enable drive to downstream gated SR latch.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 cmd_count  output  CNT_W  number of completed commands, wraps modulo 2^CNT_W.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from current level; any mismatch restarts the count.
REQ-014 A command request SHALL be the debounced 0->1 edge of a button (one-cycle strobe); falling edges, held levels and bounces shorter than DEBOUNCE_CYCLES SHALL generate nothing.
REQ-015 FSM states: IDLE, SETUP, ENABLE, HOLD.
REQ-016 IDLE: S=R=E=0; on a request latch cmd (SET or RESET) and go to SETUP next cycle.
REQ-017 SETUP (1 cycle): drive S=1 (SET) or R=1 (RESET), E=0; go to ENABLE.
REQ-018 ENABLE (PULSE_CYCLES cycles): same S/R as SETUP, E=1; then HOLD.
REQ-019 HOLD (1 cycle): same S/R, E=0; increment cmd_count; return to IDLE.
REQ-020 S and R SHALL never be 1 in the same cycle, in any state, including reset exit.
REQ-021 E SHALL only be 1 while exactly one of S/R is 1, and S/R SHALL be stable one cycle before E rises and one cycle after E falls.
REQ-022 Simultaneous set and reset strobes in IDLE: RESET command wins; set strobe discarded.
REQ-023 Strobes arriving while busy=1 SHALL be discarded (no queueing).
REQ-024 Latency: debounced edge in cycle N -> SETUP in N+1, E rises N+2, E falls N+2+PULSE_CYCLES, busy low N+3+PULSE_CYCLES.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 rst=1 SHALL immediately force FSM=IDLE, S=R=E=0, busy=0, cmd_count=0, synchronizers, debounced levels and debounce counters to 0, regardless of clock.
REQ-027 rst asserted mid-command SHALL abort it without incrementing cmd_count; a button held across reset release SHALL produce one command once debounced.

Configuration
REQ-028 Macro SR_DRIVER_TOGGLE_EN: when defined, adds input btn_toggle (1 bit, same sync/debounce path) and internal bit q_track (reset 0, updated at HOLD to 1 for SET, 0 for RESET); a toggle strobe issues RESET if q_track=1 else SET; priority reset > set > toggle.
REQ-029 Without SR_DRIVER_TOGGLE_EN: no btn_toggle port, no q_track, behaviour exactly REQ-013..027.

Verification
REQ-030 Defaults; btn_set held 20 cycles -> one SETUP/ENABLE/HOLD sequence, S=1 for 4 cycles, E=1 for 2, R=0 throughout, cmd_count=1.
REQ-031 btn_reset glitches 3 cycles high, 3 low, repeated -> no command, S=R=E=0, cmd_count=0.
REQ-032 btn_set and btn_reset rise on same cycle -> only R pulses, cmd_count=1, S never 1.
REQ-033 btn_reset pressed while busy from a set command -> set completes, reset ignored, cmd_count=1; after release and repress -> R command, cmd_count=2.
REQ-034 rst asserted during ENABLE -> S=R=E=0 and busy=0 without a clock edge, cmd_count=0.
REQ-035 With SR_DRIVER_TOGGLE_EN: three btn_toggle presses -> SET, RESET, SET commands; cmd_count=3; with CNT_W=2, five commands -> cmd_count=1.
